// File: rtl/div32_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div32_sequencer
// Description : Multi-cycle signed divider for the CPU ALU. A start pulse
//               latches a dividend/divisor pair. Non-restoring division then
//               runs one quotient bit per clock over an A/Q/M register set,
//               followed by remainder fix-up and sign correction. The result
//               is {remainder, quotient}, which matches the HI/LO write-back
//               path.
//
// Ports       : clock        rising-edge clock
//               reset_n      synchronous active-low reset
//               start        request; accepted only in IDLE or DONE
//               dividend     signed dividend, latched on accepted start
//               divisor      signed divisor, latched on accepted start
//               busy         high while an operation is in flight
//               done         one-cycle pulse, result valid
//               div_by_zero  valid with done; divisor was zero
//               result       {remainder, quotient}; held until next update
//
// Build option: DIV32_ZERO_DETECT_EN
//               When defined, a zero divisor short-circuits from SETUP
//               straight to DONE and raises div_by_zero.
//               When undefined, a zero divisor runs the normal sequence and
//               div_by_zero is tied low.
//
// Revision    : 1.0  initial release
// ============================================================================
module div32_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   result
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_SIGN  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // The step counter must be able to hold WIDTH itself.
  localparam int CNT_W = $clog2(WIDTH + 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]          state;
  logic [CNT_W-1:0]    step_count;
  logic [2*WIDTH-1:0]  result_reg;

  logic [WIDTH-1:0]    dividend_lat;
  logic [WIDTH-1:0]    divisor_lat;
  logic                sign_q;        // quotient must be negated
  logic                sign_r;        // remainder takes the dividend's sign

  logic [WIDTH:0]      acc;           // A: partial remainder, one guard bit
  logic [WIDTH-1:0]    quo;           // Q: dividend magnitude / quotient bits
  logic [WIDTH-1:0]    mag_m;         // M: divisor magnitude

`ifdef DIV32_ZERO_DETECT_EN
  logic                dbz_reg;
`endif

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic                accept;
  logic [WIDTH-1:0]    dividend_mag;
  logic [WIDTH-1:0]    divisor_mag;
  logic [WIDTH:0]      m_ext;
  logic [WIDTH:0]      acc_shift;
  logic [WIDTH:0]      acc_step;
  logic [WIDTH-1:0]    quo_step;
  logic [WIDTH:0]      acc_fix;
  logic [WIDTH-1:0]    quotient_signed;
  logic [WIDTH-1:0]    remainder_signed;

  // A start is honoured only when no operation is in flight. Accepting in
  // DONE lets operations issue back to back without an idle gap.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  // Two's-complement magnitudes. The most-negative value maps onto itself.
  // That value is still correct when it is read as an unsigned magnitude.
  assign dividend_mag = dividend_lat[WIDTH-1] ? (~dividend_lat + 1'b1) : dividend_lat;
  assign divisor_mag  = divisor_lat[WIDTH-1]  ? (~divisor_lat + 1'b1)  : divisor_lat;

  assign m_ext = {1'b0, mag_m};

  // One non-restoring step. First shift {A,Q} left by one. The sign of the
  // old A selects whether M is added or subtracted. The new quotient bit is
  // the inverse of the sign of the new A.
  assign acc_shift = {acc[WIDTH-1:0], quo[WIDTH-1]};
  assign acc_step  = acc[WIDTH] ? (acc_shift + m_ext) : (acc_shift - m_ext);
  assign quo_step  = {quo[WIDTH-2:0], ~acc_step[WIDTH]};

  // After the last step a negative A is restored once, so that the
  // remainder magnitude is non-negative.
  assign acc_fix = acc[WIDTH] ? (acc + m_ext) : acc;

  assign quotient_signed  = sign_q ? (~quo + 1'b1) : quo;
  assign remainder_signed = sign_r ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];

  // --------------------------------------------------------------------------
  // Control: state, step counter and architecturally visible result
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      step_count <= '0;
      result_reg <= '0;
`ifdef DIV32_ZERO_DETECT_EN
      dbz_reg    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_SETUP;
          end
        end

        S_SETUP: begin
`ifdef DIV32_ZERO_DETECT_EN
          if (divisor_lat == '0) begin
            // Short-circuit: quotient all ones, remainder is the dividend.
            state      <= S_DONE;
            result_reg <= {dividend_lat, {WIDTH{1'b1}}};
            dbz_reg    <= 1'b1;
          end else begin
            state      <= S_ITER;
            step_count <= CNT_W'(WIDTH);
          end
`else
          state      <= S_ITER;
          step_count <= CNT_W'(WIDTH);
`endif
        end

        S_ITER: begin
          step_count <= step_count - 1'b1;
          if (step_count == CNT_W'(1)) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          state <= S_SIGN;
        end

        S_SIGN: begin
          state      <= S_DONE;
          result_reg <= {remainder_signed, quotient_signed};
`ifdef DIV32_ZERO_DETECT_EN
          dbz_reg    <= 1'b0;
`endif
        end

        S_DONE: begin
          state <= accept ? S_SETUP : S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers. Their contents are don't-care outside an operation,
  // so they carry no reset. The control state gates every use of them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (accept) begin
      dividend_lat <= dividend;
      divisor_lat  <= divisor;
      sign_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r       <= dividend[WIDTH-1];
    end

    case (state)
      S_SETUP: begin
        acc   <= '0;
        quo   <= dividend_mag;
        mag_m <= divisor_mag;
      end
      S_ITER: begin
        acc <= acc_step;
        quo <= quo_step;
      end
      S_FIX: begin
        acc <= acc_fix;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy   = (state == S_SETUP) || (state == S_ITER) ||
                  (state == S_FIX)   || (state == S_SIGN);
  assign done   = (state == S_DONE);
  assign result = result_reg;

`ifdef DIV32_ZERO_DETECT_EN
  assign div_by_zero = dbz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div32_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_div32_sequencer
// Description : Self-checking bench for div32_sequencer. Each scenario task
//               does three things. It drives requests, pushes the expected
//               {remainder, quotient}, flag and done cycle to a scoreboard
//               queue, and pops and compares when done is seen.
// Revision    : 1.0  initial release
// ============================================================================
module tb_div32_sequencer;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 4;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   dividend = '0;
  logic [WIDTH-1:0]   divisor = '0;
  logic               busy;
  logic               done;
  logic               div_by_zero;
  logic [2*WIDTH-1:0] result;

  div32_sequencer #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  always #5 clock = ~clock;

  // Cycle index. The value read after a rising edge names the current cycle.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic [63:0] mask;
    logic        dbz;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: truncating signed division in 64-bit arithmetic. This
  // makes the most-negative / -1 case wrap exactly as 32-bit hardware does.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sd, q, r;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    q  = sa / sd;
    r  = sa % sd;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic push_exp(input string name, input logic [63:0] res, input logic [63:0] mask,
                          input logic dbz, input int due);
    exp_t e;
    e.name = name; e.res = res; e.mask = mask; e.dbz = dbz; e.due = due;
    sb.push_back(e);
  endtask

  // Drives a one-cycle start request. On return the bench is in cycle N+1,
  // and n holds N. The operands are scrambled after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output int n);
    @(posedge clock); #1;
    start = 1'b1; dividend = a; divisor = b;
    n = cyc;
    @(posedge clock); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
  endtask

  // Waits, with a bound, for done. The task counts every cycle in which busy
  // is wrong: busy must be high before done and low in the done cycle.
  task automatic wait_done(output int done_cyc, output int busy_bad, output bit timeout);
    busy_bad = 0; timeout = 1'b1; done_cyc = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        done_cyc = cyc; timeout = 1'b0;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({busy, done, div_by_zero, result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b result=%h, expected all zero",
               busy, done, div_by_zero, result);
    end
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  // --------------------------------------------------------------------------
  logic [31:0] tab_a [8] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000,
                             32'd7, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF};
  logic [31:0] tab_b [8] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                             32'd100, 32'd1, 32'd5, 32'h8000_0000};
  logic [63:0] tab_r [8] = '{64'h0000_0002_0000_000E, 64'hFFFF_FFFE_FFFF_FFF2,
                             64'h0000_0002_FFFF_FFF2, 64'h0000_0000_8000_0000,
                             64'h0000_0007_0000_0000, 64'h0000_0000_FFFF_FFFF,
                             64'h0000_0000_0000_0000, 64'h7FFF_FFFF_0000_0000};

  task automatic test_signed_divide;
    int n, dc, bb; bit to;
    exp_t e;
    logic [63:0] held;
    logic [31:0] a, b;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        a = tab_a[i]; b = tab_b[i];
      end else begin
        a = $urandom; b = $urandom;
        if (i[0]) b = b >> $urandom_range(31, 16);
        if (b == 32'd0) b = 32'd3;
      end
      issue(a, b, n);
      push_exp($sformatf("div%0d", i), (i < 8) ? tab_r[i] : model(a, b), '1, 1'b0, n + LAT);
      wait_done(dc, bb, to);
      e = sb.pop_front();
      checks++;
      if (to || dc !== e.due) begin
        errors++;
        $display("FAIL %s_latency: got done cycle %0d (timeout=%0d), expected %0d", e.name, dc, to, e.due);
      end
      checks++;
      if (bb !== 0) begin
        errors++;
        $display("FAIL %s_busy: got %0d wrong busy cycles, expected 0", e.name, bb);
      end
      checks++;
      if (result !== e.res || div_by_zero !== e.dbz) begin
        errors++;
        $display("FAIL %s_result: got %h dbz=%b for %h/%h, expected %h dbz=%b",
                 e.name, result, div_by_zero, a, b, e.res, e.dbz);
      end
      held = result;
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || result !== held) begin
        errors++;
        $display("FAIL %s_hold: got done=%b result=%h, expected done=0 result=%h", e.name, done, result, held);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_divide_by_zero;
    int n, dc, bb; bit to;
    exp_t e;
    issue(32'd55, 32'd0, n);
`ifdef DIV32_ZERO_DETECT_EN
    push_exp("dbz", 64'h0000_0037_FFFF_FFFF, '1, 1'b1, n + 2);
`else
    push_exp("dbz", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0, n + LAT);
`endif
    wait_done(dc, bb, to);
    e = sb.pop_front();
    checks++;
    if (to || dc !== e.due) begin
      errors++;
      $display("FAIL dbz_latency: got done cycle %0d (timeout=%0d), expected %0d", dc, to, e.due);
    end
    checks++;
    if (bb !== 0) begin
      errors++;
      $display("FAIL dbz_busy: got %0d wrong busy cycles, expected 0", bb);
    end
    checks++;
    if ((result & e.mask) !== (e.res & e.mask) || div_by_zero !== e.dbz) begin
      errors++;
      $display("FAIL dbz_result: got %h dbz=%b, expected %h (mask %h) dbz=%b",
               result, div_by_zero, e.res, e.mask, e.dbz);
    end
  endtask

  // --------------------------------------------------------------------------
  // A start pulse during busy must not disturb the running operation.
  task automatic test_busy_ignore;
    int n, dc, bb; bit to;
    exp_t e;
    issue(32'd100, 32'd7, n);
    push_exp("ignore", 64'h0000_0002_0000_000E, '1, 1'b0, n + LAT);
    repeat (4) @(posedge clock);
    #1 start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clock); #1 start = 1'b0;
    wait_done(dc, bb, to);
    e = sb.pop_front();
    checks++;
    if (to || dc !== e.due || bb !== 0) begin
      errors++;
      $display("FAIL ignore_timing: got done cycle %0d busy_bad=%0d timeout=%0d, expected %0d 0 0",
               dc, bb, to, e.due);
    end
    checks++;
    if (result !== e.res || div_by_zero !== e.dbz) begin
      errors++;
      $display("FAIL ignore_result: got %h dbz=%b, expected %h dbz=%b", result, div_by_zero, e.res, e.dbz);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_op;
    int n, dc, bb, bad; bit to;
    exp_t e;
    issue(32'd100, 32'd7, n);
    repeat (4) @(posedge clock);
    #1 start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clock); #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, div_by_zero, result} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b dbz=%b result=%h, expected all zero",
               busy, done, div_by_zero, result);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midreset_stays_idle: got %0d active cycles, expected 0", bad);
    end
    issue(32'd9, 32'd3, n);
    push_exp("after_reset", 64'h0000_0000_0000_0003, '1, 1'b0, n + LAT);
    wait_done(dc, bb, to);
    e = sb.pop_front();
    checks++;
    if (to || dc !== e.due || bb !== 0) begin
      errors++;
      $display("FAIL after_reset_timing: got done cycle %0d busy_bad=%0d timeout=%0d, expected %0d 0 0",
               dc, bb, to, e.due);
    end
    checks++;
    if (result !== e.res) begin
      errors++;
      $display("FAIL after_reset_result: got %h, expected %h", result, e.res);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back;
    int n1, dc, bb; bit to;
    exp_t e;
    @(posedge clock); #1;
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    n1 = cyc;
    push_exp("b2b_first", 64'h0000_0000_0000_0064, '1, 1'b0, n1 + LAT);
    @(posedge clock); #1;
    dividend = 32'hFFFF_FFF9; divisor = 32'd2;   // start stays high
    wait_done(dc, bb, to);
    push_exp("b2b_second", 64'hFFFF_FFFF_FFFF_FFFD, '1, 1'b0, n1 + 2 * LAT);
    e = sb.pop_front();
    checks++;
    if (to || dc !== e.due || bb !== 0 || result !== e.res) begin
      errors++;
      $display("FAIL b2b_first: got cycle %0d busy_bad=%0d timeout=%0d result=%h, expected %0d 0 0 %h",
               dc, bb, to, result, e.due, e.res);
    end
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reassert: got busy=%b done=%b, expected 1 0", busy, done);
    end
    wait_done(dc, bb, to);
    e = sb.pop_front();
    checks++;
    if (to || dc !== e.due || bb !== 0) begin
      errors++;
      $display("FAIL b2b_second_timing: got cycle %0d busy_bad=%0d timeout=%0d, expected %0d 0 0",
               dc, bb, to, e.due);
    end
    checks++;
    if (result !== e.res || div_by_zero !== e.dbz) begin
      errors++;
      $display("FAIL b2b_second_result: got %h dbz=%b, expected %h dbz=%b", result, div_by_zero, e.res, e.dbz);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_signed_divide();
    test_divide_by_zero();
    test_busy_ignore();
    test_reset_mid_op();
    test_back_to_back();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by %0t, expected finish earlier", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/div32_sequencer.md
# div32_sequencer

Multi-cycle signed 32-bit divide controller for the CPU ALU. Accepts a dividend/divisor pair on a start pulse, runs non-restoring division one step per clock over an internal A/Q/M register set, and applies sign correction. It returns a 64-bit result: remainder in the upper half, quotient in the lower half, matching the HI/LO write-back path. It frees the ALU from a combinational 32-deep divide chain and gives the control unit a busy/done handshake to stall on.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH; latency scales as WIDTH+4
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  WIDTH  signed two's-complement Q, latched on accepted start
- divisor  input  WIDTH  signed two's-complement M, latched on accepted start
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse, result valid
- div_by_zero  output  1  valid with done; divisor was zero
- result  output  2*WIDTH  {remainder, quotient}; holds until next accepted start

## Operation
- States: IDLE, SETUP, ITER, FIX, SIGN, DONE.
- IDLE/DONE: start=1 latches operands, records sign_q = dividend MSB ^ divisor MSB and sign_r = dividend MSB, then goes to SETUP. Otherwise DONE returns to IDLE.
- SETUP: loads |dividend| into Q and |divisor| into M as unsigned WIDTH-bit magnitudes. A (WIDTH+1 bits) is cleared. Step counter = WIDTH. Goes to ITER.
- ITER, one step per cycle:
  - shift {A,Q} left 1;
  - if the old A MSB = 1, A = A + M, else A = A - M;
  - Q[0] = ~A_new MSB;
  - decrement the counter; leave for FIX when it reaches 0.
- FIX: if A MSB = 1, A = A + M, which makes the remainder non-negative.
- SIGN: quotient = sign_q ? -Q : Q; remainder = sign_r ? -A[WIDTH-1:0] : A. Both are written to result. Goes to DONE.
- Most-negative operand: |0x80000000| = 0x80000000 as unsigned. 0x80000000 / -1 gives quotient 0x80000000 (wraps) and remainder 0. No overflow flag.
- Divide by zero, with the macro enabled: detected in SETUP. Jumps to DONE with quotient = all ones, remainder = dividend, div_by_zero=1.
- start while busy is ignored. Operand changes after acceptance have no effect.

## Timing
- N = cycle in which start is accepted.
- Normal operation:
  - SETUP: N+1
  - ITER: N+2..N+33
  - FIX: N+34
  - SIGN: N+35
  - DONE: N+36, with done=1 and busy=0
- busy is high during N+1..N+35. done is high exactly one cycle.
- Divide by zero: SETUP at N+1, DONE at N+2, busy high during N+1 only.
- result and div_by_zero update on the edge entering DONE and are stable while done=1.
- Back-to-back: start=1 during the DONE cycle is accepted, giving SETUP the next cycle and no idle gap.
- Reset (reset_n=0 at an edge), in any state including mid-ITER: goes to IDLE; busy=0, done=0, div_by_zero=0, result=0, counter=0. Internal A/Q/M are don't-care.

## Configuration
- DIV32_ZERO_DETECT_EN defined: zero-divisor short-circuit as specified above.
- Not defined: no zero check, and div_by_zero is tied to 0.
  - A zero divisor runs the full WIDTH+4 cycle sequence.
  - The result is whatever the algorithm produces: quotient 0xFFFFFFFF for non-negative dividends, remainder implementation-defined but deterministic.

## Test plan
- 100 / 7 started at N -> done at N+36; result = {0x00000002, 0x0000000E}; busy high N+1..N+35.
- -100 / 7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); 100 / -7 -> quotient 0xFFFFFFF2, remainder 0x00000002.
- 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero=0.
- 55 / 0 with DIV32_ZERO_DETECT_EN -> done at N+2, div_by_zero=1, result = {0x00000037, 0xFFFFFFFF}; without the macro -> done at N+36, div_by_zero=0.
- Start 100/7, pulse start with 9/3 at N+5, then assert reset_n=0 at N+10 -> the N+5 start is ignored. After reset all outputs are 0 and state is IDLE. A new 9/3 started after reset -> quotient 3, remainder 0, 36 cycles later.
- start held high across DONE -> second operation accepted in the DONE cycle, busy re-asserts the next cycle, second done 36 cycles after the first.
